div_mod_8bit: RTL and testbench

DIV_MOD_8BIT -- requirements
Module: div_mod_8bit

---
 rtl/div_mod_pkg.sv | 10 +
 rtl/div_mod_step.sv | 19 +
 rtl/div_mod_8bit.sv | 108 ++++++++++
 tb/tb_div_mod_8bit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/div_mod_pkg.sv
// Shared types and defaults for the 8-bit restoring divider.
package div_mod_pkg;
  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/div_mod_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, subtract divisor if it fits.
module div_mod_step #(
  parameter int WIDTH = div_mod_pkg::DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_ext;

  assign shifted = {rem_i, bit_i};
  assign dvs_ext = {2'b00, divisor_i};
  assign q_o     = (shifted >= dvs_ext);
  // The partial remainder stays below the divisor, so the top bit is always zero here.
  assign rem_o   = q_o ? (WIDTH+1)'(shifted - dvs_ext) : (WIDTH+1)'(shifted);
endmodule

// File: rtl/div_mod_8bit.sv
// Multi-cycle unsigned divider: one quotient bit per cycle, MSB first, with a divide-by-zero shortcut.
module div_mod_8bit
  import div_mod_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend bits shift out the top, quotient bits shift in below
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  div_mod_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    case (state_q)
      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          quot_d  = {dvd_q[WIDTH-2:0], step_q};
          remo_d  = step_rem[WIDTH-1:0];
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          cnt_d = '0;
          rem_d = '0;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            quot_d  = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_mod_8bit.sv
// Randomized and directed checks of div_mod_8bit against plain integer division.
module tb_div_mod_8bit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] prev_q = '0, prev_r = '0;

  div_mod_8bit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive start with operands so the next rising edge accepts them.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
  endtask

  // Follow an accepted op from cycle 1 to its done cycle; poke>0 re-pulses start (9/3) in that cycle.
  task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b, input int poke,
                           input bit full);
    int dc = 0, nb = 0;
    bit overlap = 0, hold_ok = 1;
    int eq, er;
    eq = (b == 0) ? (1 << W) - 1 : a / b;
    er = (b == 0) ? a : a % b;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (busy && done) overlap = 1;
      if (done) begin dc = cyc; break; end
      if (busy) begin
        nb++;
        if (quotient !== prev_q || remainder !== prev_r || div_by_zero !== 1'b0) hold_ok = 0;
      end
      if (cyc == poke) begin start = 1'b1; dividend = 8'd9; divisor = 8'd3; end
      else begin start = 1'b0; dividend = W'($urandom); divisor = W'($urandom); end
    end
    chk("quotient", 32'(quotient), eq);
    chk("remainder", 32'(remainder), er);
    if (full) begin
      chk("done_cycle", dc, (b == 0) ? 1 : W + 1);
      chk("busy_cycles", nb, (b == 0) ? 0 : W);
      chk("div_by_zero", 32'(div_by_zero), (b == 0) ? 1 : 0);
      chk("busy_done_overlap", 32'(overlap), 0);
      chk("hold_during_calc", 32'(hold_ok), 1);
    end
    if (b != 0) begin
      chk("identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      chk("rem_lt_div", 32'(remainder < b), 1);
    end
    prev_q = quotient; prev_r = remainder;
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit saw_done;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_quotient", 32'(quotient), 0);
    chk("rst_remainder", 32'(remainder), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    // 200/7, started immediately after reset release
    launch(8'd200, 8'd7);
    wait_done(8'd200, 8'd7, 0, 1);
    @(negedge clk);
    chk("done_single_cycle", 32'(done), 0);
    chk("quot_hold_idle", 32'(quotient), 28);

    // 255/1 then 5/9 back to back from the DONE cycle
    launch(8'd255, 8'd1);
    wait_done(8'd255, 8'd1, 0, 1);
    launch(8'd5, 8'd9);
    wait_done(8'd5, 8'd9, 0, 1);
    @(negedge clk);

    // divide by zero
    launch(8'd17, 8'd0);
    wait_done(8'd17, 8'd0, 0, 1);
    @(negedge clk);
    chk("dbz_hold", 32'(div_by_zero), 1);

    // second start during CALC is ignored
    launch(8'd100, 8'd10);
    wait_done(8'd100, 8'd10, 4, 1);
    @(negedge clk);
    chk("no_restart", 32'(busy | done), 0);

    // async reset mid-cycle 4 of 200/7
    launch(8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_quotient", 32'(quotient), 0);
    chk("abort_remainder", 32'(remainder), 0);
    chk("abort_dbz", 32'(div_by_zero), 0);
    @(negedge clk); rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy || quotient != 0 || remainder != 0) saw_done = 1;
    end
    chk("abort_quiet", 32'(saw_done), 0);
    prev_q = '0; prev_r = '0;

    // random nonzero divisors, sometimes back to back
    for (int n = 0; n < 1000; n++) begin
      a = W'($urandom);
      b = W'($urandom_range(1, (1 << W) - 1));
      launch(a, b);
      wait_done(a, b, 0, (n % 50) == 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
